// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the EX stage: ID->EX bus layout, ALU op bit
// positions, stall encoding and bus widths.
// Ports: none (package).
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int STALL_WD     = 6;

  // Per-stage stall vector encoding.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit positions inside the one-hot alu_op field.
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // Operand-select bit positions.
  localparam int SRC1_RS   = 0;
  localparam int SRC1_PC   = 1;
  localparam int SRC1_SA   = 2;
  localparam int SRC2_RT   = 0;
  localparam int SRC2_SIMM = 1;
  localparam int SRC2_8    = 2;
  localparam int SRC2_ZIMM = 3;

  // ID->EX bus, MSB first (pc occupies 158:127, rdata2 occupies 31:0).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational MIPS ALU driven by a one-hot op vector; an all-zero op gives 0.
// Ports: alu_op[11:0] one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui},
//        src_a/src_b 32-bit operands (shift amount is src_a[4:0]), result 32-bit.
module alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] lui_res;

  assign add_res  = src_a + src_b;
  assign sub_res  = src_a - src_b;
  assign slt_res  = {31'b0, $signed(src_a) < $signed(src_b)};
  assign sltu_res = {31'b0, src_a < src_b};
  assign sll_res  = src_b << src_a[4:0];
  assign srl_res  = src_b >> src_a[4:0];
  assign sra_res  = $unsigned($signed(src_b) >>> src_a[4:0]);
  assign lui_res  = {src_b[15:0], 16'b0};

  // AND-OR mux: each term is masked by its own op bit, so no op selects 0.
  assign result = ({32{alu_op[ALU_ADD]}}  & add_res)
                | ({32{alu_op[ALU_SUB]}}  & sub_res)
                | ({32{alu_op[ALU_SLT]}}  & slt_res)
                | ({32{alu_op[ALU_SLTU]}} & sltu_res)
                | ({32{alu_op[ALU_AND]}}  & (src_a & src_b))
                | ({32{alu_op[ALU_NOR]}}  & ~(src_a | src_b))
                | ({32{alu_op[ALU_OR]}}   & (src_a | src_b))
                | ({32{alu_op[ALU_XOR]}}  & (src_a ^ src_b))
                | ({32{alu_op[ALU_SLL]}}  & sll_res)
                | ({32{alu_op[ALU_SRL]}}  & srl_res)
                | ({32{alu_op[ALU_SRA]}}  & sra_res)
                | ({32{alu_op[ALU_LUI]}}  & lui_res);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ID bus, runs the ALU, issues the data SRAM request.
// Latency: 1 cycle (input register); all outputs are combinational from it.
// Backpressure: stall[2] holds the register, stall[2]&~stall[3] inserts a bubble.
// Ports: clk, rst (sync, active-high), stall[5:0], id_to_ex_bus[158:0] in;
//        ex_to_mem_bus[75:0], ex_to_rf_bus[37:0], ex_is_load, data_sram_en,
//        data_sram_wen[3:0], data_sram_addr[31:0], data_sram_wdata[31:0] out.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  id_to_ex_t id_to_ex_q;
  id_to_ex_t id_to_ex_d;

  // EX stalled while MEM proceeds -> bubble; EX free -> accept; else hold.
  always_comb begin
    id_to_ex_d = id_to_ex_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) begin
      id_to_ex_d = '0;
    end else if (stall[2] == NO_STOP) begin
      id_to_ex_d = id_to_ex_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_q <= '0;
    end else begin
      id_to_ex_q <= id_to_ex_d;
    end
  end

  logic [15:0] imm;
  logic [4:0]  sa;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] ex_result;

  assign imm = id_to_ex_q.inst[15:0];
  assign sa  = id_to_ex_q.inst[10:6];

  assign src_a = ({32{id_to_ex_q.src1[SRC1_RS]}} & id_to_ex_q.rdata1)
               | ({32{id_to_ex_q.src1[SRC1_PC]}} & id_to_ex_q.pc)
               | ({32{id_to_ex_q.src1[SRC1_SA]}} & {27'b0, sa});

  assign src_b = ({32{id_to_ex_q.src2[SRC2_RT]}}   & id_to_ex_q.rdata2)
               | ({32{id_to_ex_q.src2[SRC2_SIMM]}} & sext16(imm))
               | ({32{id_to_ex_q.src2[SRC2_8]}}    & 32'd8)
               | ({32{id_to_ex_q.src2[SRC2_ZIMM]}} & {16'b0, imm});

  alu u_alu (
    .alu_op (id_to_ex_q.alu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (ex_result)
  );

  // Store lane steering: byte/half enables follow the low address bits, data
  // is replicated across lanes so the SRAM picks whichever lane is enabled.
  // A misaligned halfword simply loses the bits shifted past lane 3.
  logic [3:0]  wen_lane;
  logic [31:0] wdata_lane;

  always_comb begin
    wen_lane   = id_to_ex_q.ram_wen;
    wdata_lane = id_to_ex_q.rdata2;
    case (id_to_ex_q.ram_wen)
      4'b0001: begin
        wen_lane   = 4'b0001 << ex_result[1:0];
        wdata_lane = {4{id_to_ex_q.rdata2[7:0]}};
      end
      4'b0011: begin
        wen_lane   = 4'b0011 << ex_result[1:0];
        wdata_lane = {2{id_to_ex_q.rdata2[15:0]}};
      end
      4'b1111: begin
        wen_lane   = 4'b1111;
        wdata_lane = id_to_ex_q.rdata2;
      end
      default: ;
    endcase
  end

  logic [3:0] wen_gated;
  assign wen_gated = id_to_ex_q.ram_en ? wen_lane : 4'b0000;

  assign data_sram_en    = id_to_ex_q.ram_en;
  assign data_sram_wen   = wen_gated;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = wdata_lane;

  // Forwarding carries the raw ALU result even for loads; ID uses ex_is_load
  // to stall instead of forwarding an address as data.
  assign ex_is_load = id_to_ex_q.ram_en & ~|wen_gated;

  assign ex_to_rf_bus = {id_to_ex_q.rf_we, id_to_ex_q.rf_waddr, ex_result};

  assign ex_to_mem_bus = {id_to_ex_q.pc, id_to_ex_q.ram_en, wen_gated,
                          id_to_ex_q.sel_rf_res, id_to_ex_q.rf_we,
                          id_to_ex_q.rf_waddr, ex_result};

  // Only the immediate and shift-amount fields of the instruction word feed EX.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_to_ex_q.inst[31:16]};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_is_load      (ex_is_load),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;
  localparam logic [2:0]  S1_RS   = 3'b001;
  localparam logic [2:0]  S1_PC   = 3'b010;
  localparam logic [2:0]  S1_SA   = 3'b100;
  localparam logic [3:0]  S2_RT   = 4'b0001;
  localparam logic [3:0]  S2_SIMM = 4'b0010;
  localparam logic [3:0]  S2_8    = 4'b0100;
  localparam logic [3:0]  S2_ZIMM = 4'b1000;

  typedef struct {
    logic [158:0] bus;
    logic [31:0]  res;
    logic         en;
    logic [3:0]   wen;
    logic [31:0]  wdata;
    logic         ld;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ren,
    input logic [3:0] rwen, input logic we, input logic [4:0] waddr,
    input logic sel, input logic [31:0] rd1, input logic [31:0] rd2);
    return {pc, inst, op, s1, s2, ren, rwen, we, waddr, sel, rd1, rd2};
  endfunction

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input string tag);
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic        sel;
    pc    = vecs[i].bus[158:127];
    we    = vecs[i].bus[70];
    waddr = vecs[i].bus[69:65];
    sel   = vecs[i].bus[64];
    chk($sformatf("%s[%0d].mem_bus", tag, i), 76'(ex_to_mem_bus),
        {pc, vecs[i].en, vecs[i].wen, sel, we, waddr, vecs[i].res});
    chk($sformatf("%s[%0d].rf_bus", tag, i), 76'(ex_to_rf_bus),
        76'({we, waddr, vecs[i].res}));
    chk($sformatf("%s[%0d].is_load", tag, i), 76'(ex_is_load), 76'(vecs[i].ld));
    chk($sformatf("%s[%0d].sram_en", tag, i), 76'(data_sram_en), 76'(vecs[i].en));
    chk($sformatf("%s[%0d].sram_wen", tag, i), 76'(data_sram_wen), 76'(vecs[i].wen));
    chk($sformatf("%s[%0d].sram_addr", tag, i), 76'(data_sram_addr), 76'(vecs[i].res));
    if (vecs[i].wen != 4'b0000)
      chk($sformatf("%s[%0d].sram_wdata", tag, i), 76'(data_sram_wdata), 76'(vecs[i].wdata));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mem_bus"}, 76'(ex_to_mem_bus), 76'd0);
    chk({tag, ".rf_bus"}, 76'(ex_to_rf_bus), 76'd0);
    chk({tag, ".is_load"}, 76'(ex_is_load), 76'd0);
    chk({tag, ".sram_en"}, 76'(data_sram_en), 76'd0);
    chk({tag, ".sram_wen"}, 76'(data_sram_wen), 76'd0);
    chk({tag, ".sram_addr"}, 76'(data_sram_addr), 76'd0);
    chk({tag, ".sram_wdata"}, 76'(data_sram_wdata), 76'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pc, inst, op, src1, src2, ram_en, ram_wen, rf_we, waddr, sel, rdata1, rdata2
    vecs[0]  = '{bus: mk(32'hBFC00010, 32'h24850001, OP_ADD, S1_RS, S2_SIMM, 1'b0, 4'b0000, 1'b1, 5'd5, 1'b0, 32'h7FFFFFFF, 32'h0),
                 res: 32'h80000000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[1]  = '{bus: mk(32'hBFC00014, 32'hA0A20000, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h00001003, 32'h000000AB),
                 res: 32'h00001003, en: 1'b1, wen: 4'b1000, wdata: 32'hABABABAB, ld: 1'b0};
    vecs[2]  = '{bus: mk(32'hBFC00000, 32'h0C000000, OP_ADD, S1_PC, S2_8, 1'b0, 4'b0000, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0),
                 res: 32'hBFC00008, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[3]  = '{bus: mk(32'hBFC00020, 32'h00021103, OP_SRA, S1_SA, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd2, 1'b0, 32'h0, 32'h80000000),
                 res: 32'hF8000000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[4]  = '{bus: mk(32'hBFC00024, 32'hA4A20002, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0, 32'h00002001, 32'h1234CDEF),
                 res: 32'h00002003, en: 1'b1, wen: 4'b1000, wdata: 32'hCDEFCDEF, ld: 1'b0};
    vecs[5]  = '{bus: mk(32'hBFC00028, 32'hA4A20001, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0, 32'h00002001, 32'h1234CDEF),
                 res: 32'h00002002, en: 1'b1, wen: 4'b1100, wdata: 32'hCDEFCDEF, ld: 1'b0};
    vecs[6]  = '{bus: mk(32'hBFC0002C, 32'hA4A2FFFF, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0, 32'h00002001, 32'h00005A5A),
                 res: 32'h00002000, en: 1'b1, wen: 4'b0011, wdata: 32'h5A5A5A5A, ld: 1'b0};
    vecs[7]  = '{bus: mk(32'hBFC00030, 32'hACA20004, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b1111, 1'b0, 5'd0, 1'b0, 32'h00003000, 32'h89ABCDEF),
                 res: 32'h00003004, en: 1'b1, wen: 4'b1111, wdata: 32'h89ABCDEF, ld: 1'b0};
    vecs[8]  = '{bus: mk(32'hBFC00034, 32'h8CA40008, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0000, 1'b1, 5'd4, 1'b1, 32'h00004000, 32'h0),
                 res: 32'h00004008, en: 1'b1, wen: 4'b0000, wdata: 32'h0, ld: 1'b1};
    vecs[9]  = '{bus: mk(32'hBFC00038, 32'h0, OP_SLT, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd8, 1'b0, 32'hFFFFFFFF, 32'h00000001),
                 res: 32'h00000001, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[10] = '{bus: mk(32'hBFC0003C, 32'h0, OP_SLTU, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd9, 1'b0, 32'hFFFFFFFF, 32'h00000001),
                 res: 32'h00000000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[11] = '{bus: mk(32'hBFC00040, 32'h0, OP_SUB, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd10, 1'b0, 32'h00000005, 32'h00000007),
                 res: 32'hFFFFFFFE, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[12] = '{bus: mk(32'hBFC00044, 32'h0, OP_NOR, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd11, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000),
                 res: 32'h00000F0F, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[13] = '{bus: mk(32'hBFC00048, 32'h3C051234, OP_LUI, 3'b000, S2_ZIMM, 1'b0, 4'b0000, 1'b1, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0),
                 res: 32'h12340000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[14] = '{bus: mk(32'hBFC0004C, 32'h34A58001, OP_OR, S1_RS, S2_ZIMM, 1'b0, 4'b0000, 1'b1, 5'd5, 1'b0, 32'h00FF0000, 32'h0),
                 res: 32'h00FF8001, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[15] = '{bus: mk(32'hBFC00050, 32'h0, 12'h000, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd12, 1'b0, 32'h00000001, 32'h00000002),
                 res: 32'h00000000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[16] = '{bus: mk(32'hBFC00054, 32'hA0A20000, OP_ADD, S1_RS, S2_SIMM, 1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h00001003, 32'h000000AB),
                 res: 32'h00001003, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[17] = '{bus: mk(32'hBFC00058, 32'h0, OP_SLL, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd13, 1'b0, 32'h00000021, 32'h00000003),
                 res: 32'h00000006, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[18] = '{bus: mk(32'hBFC0005C, 32'h0, OP_XOR, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd14, 1'b0, 32'hFF00FF00, 32'h0FF00FF0),
                 res: 32'hF0F0F0F0, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[19] = '{bus: mk(32'hBFC00060, 32'h0, OP_AND, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd15, 1'b0, 32'hFF00FF00, 32'h0FF00FF0),
                 res: 32'h0F000F00, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[20] = '{bus: mk(32'hBFC00064, 32'h00021102, OP_SRL, S1_SA, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd2, 1'b0, 32'h0, 32'h80000000),
                 res: 32'h08000000, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};
    vecs[21] = '{bus: mk(32'hBFC00068, 32'hA0A20000, OP_ADD, S1_RS, S2_SIMM, 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h00001001, 32'h123456C3),
                 res: 32'h00001001, en: 1'b1, wen: 4'b0010, wdata: 32'hC3C3C3C3, ld: 1'b0};
    vecs[22] = '{bus: mk(32'hBFC0006C, 32'h0, OP_SLTU, S1_RS, S2_RT, 1'b0, 4'b0000, 1'b1, 5'd16, 1'b0, 32'h00000001, 32'hFFFFFFFF),
                 res: 32'h00000001, en: 1'b0, wen: 4'b0000, wdata: 32'h0, ld: 1'b0};

    // Reset: register clears, every output is zero.
    rst = 1'b1;
    stall = 6'b000000;
    id_to_ex_bus = vecs[0].bus;
    step();
    step();
    check_zero("reset");

    // Table: one instruction per cycle, no stalls.
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      id_to_ex_bus = vecs[i].bus;
      step();
      check_vec(i, "vec");
    end

    // Load in EX, then bubble: EX stalled while MEM runs.
    id_to_ex_bus = vecs[8].bus;
    stall = 6'b000000;
    step();
    check_vec(8, "bubble_pre");
    stall = 6'b000100;
    id_to_ex_bus = vecs[7].bus;
    step();
    check_zero("bubble");
    stall = 6'b000000;
    step();
    check_vec(7, "bubble_post");

    // Hold: EX and MEM both stalled for 3 cycles, request re-driven unchanged.
    stall = 6'b001100;
    id_to_ex_bus = vecs[1].bus;
    for (int c = 0; c < 3; c++) begin
      step();
      check_vec(7, $sformatf("hold%0d", c));
    end
    stall = 6'b000000;
    step();
    check_vec(1, "hold_release");

    // EX free while MEM stalled: EX still accepts.
    stall = 6'b001000;
    id_to_ex_bus = vecs[2].bus;
    step();
    check_vec(2, "ex_free");

    // Reset mid-stall wins over hold, bubble persists while held, then flows.
    stall = 6'b000000;
    id_to_ex_bus = vecs[3].bus;
    step();
    check_vec(3, "rst_pre");
    stall = 6'b001100;
    rst = 1'b1;
    id_to_ex_bus = vecs[0].bus;
    step();
    check_zero("rst_stall");
    rst = 1'b0;
    step();
    check_zero("rst_held");
    stall = 6'b000000;
    step();
    check_vec(0, "rst_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
